// File: rtl/uart_frame_rx.sv
// Framed command receiver: parses SOF/LEN/payload/CHK bytes from the uart RX FIFO,
// holds good payloads for a local consumer and answers ACK/NAK through the TX FIFO.
module uart_frame_rx #(
    parameter int unsigned DBITS   = 8,
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned TIMEOUT = 200000,
    parameter logic [7:0]  SOF     = 8'h7E,
    parameter logic [7:0]  ACK     = 8'h06,
    parameter logic [7:0]  NAK     = 8'h15,
    localparam int unsigned AW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_empty,
    input  logic [DBITS-1:0] r_data,
    output logic             rd_uart,
    input  logic             tx_full,
    output logic             wr_uart,
    output logic [DBITS-1:0] w_data,
    output logic             pkt_valid,
    output logic [7:0]       pkt_len,
    input  logic [AW-1:0]    pkt_rd_addr,
    output logic [DBITS-1:0] pkt_rd_data,
    input  logic             pkt_ack,
    output logic             err_chk,
    output logic             err_len,
    output logic             err_timeout,
    output logic [15:0]      pkt_count
);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic [2:0] StHunt = 3'd0;
    localparam logic [2:0] StLen  = 3'd1;
    localparam logic [2:0] StData = 3'd2;
    localparam logic [2:0] StChk  = 3'd3;
    localparam logic [2:0] StSend = 3'd4;
    localparam logic [2:0] StHold = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       idx_q, idx_d;
    logic [DBITS-1:0] chk_q, chk_d;
    logic [DBITS-1:0] pend_q, pend_d;
    logic             good_q, good_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [15:0]      count_q, count_d;
    logic             err_chk_q, err_chk_d;
    logic             err_len_q, err_len_d;
    logic             err_tmo_q, err_tmo_d;
    logic             pay_we;
    logic             parsing;
    logic             pop;
    logic [DBITS-1:0] pay_q [MAX_LEN];

    // Timeout only runs once a frame has started (SOF seen).
    assign parsing = (state_q == StLen) || (state_q == StData) || (state_q == StChk);
    assign rd_uart = ~reset & ~rx_empty & (parsing || (state_q == StHunt));
    assign pop     = rd_uart;
    assign wr_uart = ~reset & (state_q == StSend) & ~tx_full;
    assign w_data  = wr_uart ? pend_q : '0;

    // Valid rises together with the ACK push, then stays up through HOLD.
    assign pkt_valid   = (state_q == StHold) || ((state_q == StSend) && good_q && ~tx_full);
    assign pkt_len     = pkt_valid ? len_q : 8'd0;
    assign pkt_rd_data = (pkt_valid && (32'(pkt_rd_addr) < MAX_LEN)) ? pay_q[pkt_rd_addr] : '0;
    assign pkt_count   = count_q;
    assign err_chk     = err_chk_q;
    assign err_len     = err_len_q;
    assign err_timeout = err_tmo_q;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        chk_d     = chk_q;
        pend_d    = pend_q;
        good_d    = good_q;
        count_d   = count_q;
        err_chk_d = 1'b0;
        err_len_d = 1'b0;
        err_tmo_d = 1'b0;
        pay_we    = 1'b0;
        tmo_d     = (parsing && !pop) ? tmo_q + TW'(1) : '0;

        case (state_q)
            StHunt: begin
                if (pop && (r_data == DBITS'(SOF))) state_d = StLen;
            end
            StLen: begin
                if (pop) begin
                    if ((r_data == '0) || (32'(r_data) > MAX_LEN)) begin
                        err_len_d = 1'b1;
                        pend_d    = DBITS'(NAK);
                        good_d    = 1'b0;
                        state_d   = StSend;
                    end else begin
                        len_d   = 8'(r_data);
                        chk_d   = r_data;
                        idx_d   = 8'd0;
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (pop) begin
                    pay_we = 1'b1;
                    chk_d  = chk_q ^ r_data;
                    idx_d  = idx_q + 8'd1;
                    if (idx_q == len_q - 8'd1) state_d = StChk;
                end
            end
            StChk: begin
                if (pop) begin
                    if (r_data == chk_q) begin
                        pend_d = DBITS'(ACK);
                        good_d = 1'b1;
                    end else begin
                        pend_d    = DBITS'(NAK);
                        good_d    = 1'b0;
                        err_chk_d = 1'b1;
                    end
                    state_d = StSend;
                end
            end
            StSend: begin
                if (!tx_full) begin
                    state_d = good_q ? StHold : StHunt;
                    if (good_q) count_d = count_q + 16'd1;
                end
            end
            StHold: begin
                if (pkt_ack) state_d = StHunt;
            end
            default: state_d = StHunt;
        endcase

        // A pop on the terminal count keeps the frame alive.
        if (parsing && !pop && (tmo_q == TMO_LAST)) begin
            err_tmo_d = 1'b1;
            state_d   = StHunt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StHunt;
            len_q     <= '0;
            idx_q     <= '0;
            chk_q     <= '0;
            pend_q    <= '0;
            good_q    <= 1'b0;
            tmo_q     <= '0;
            count_q   <= '0;
            err_chk_q <= 1'b0;
            err_len_q <= 1'b0;
            err_tmo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            chk_q     <= chk_d;
            pend_q    <= pend_d;
            good_q    <= good_d;
            tmo_q     <= tmo_d;
            count_q   <= count_d;
            err_chk_q <= err_chk_d;
            err_len_q <= err_len_d;
            err_tmo_q <= err_tmo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (pay_we) pay_q[idx_q[AW-1:0]] <= r_data;
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: FIFO models on both uart sides, a frame-level
// reference parser, directed test-plan frames and a randomized frame stream.
module tb_uart_frame_rx;
    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned TIMEOUT = 64;
    localparam logic [7:0]  SOF     = 8'h7E;
    localparam logic [7:0]  ACK     = 8'h06;
    localparam logic [7:0]  NAK     = 8'h15;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_empty = 1'b1;
    logic [7:0]  r_data = 8'h00;
    logic        rd_uart;
    logic        tx_full;
    logic        wr_uart;
    logic [7:0]  w_data;
    logic        pkt_valid;
    logic [7:0]  pkt_len;
    logic [3:0]  pkt_rd_addr;
    logic [7:0]  pkt_rd_data;
    logic        pkt_ack;
    logic        err_chk;
    logic        err_len;
    logic        err_timeout;
    logic [15:0] pkt_count;

    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    logic [7:0]  frm[$];
    logic        pop_pend = 1'b0;
    logic        last_wr_valid = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_wr = 0;
    int          n_err_chk = 0;
    int          n_err_len = 0;
    int          n_err_tmo = 0;
    int          snap_wr, snap_chk, snap_len, snap_tmo;
    int          exp_kind, exp_len;
    logic [7:0]  exp_pl [MAX_LEN];
    logic [15:0] exp_count;

    uart_frame_rx #(
        .MAX_LEN(MAX_LEN),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_empty   (rx_empty),
        .r_data     (r_data),
        .rd_uart    (rd_uart),
        .tx_full    (tx_full),
        .wr_uart    (wr_uart),
        .w_data     (w_data),
        .pkt_valid  (pkt_valid),
        .pkt_len    (pkt_len),
        .pkt_rd_addr(pkt_rd_addr),
        .pkt_rd_data(pkt_rd_data),
        .pkt_ack    (pkt_ack),
        .err_chk    (err_chk),
        .err_len    (err_len),
        .err_timeout(err_timeout),
        .pkt_count  (pkt_count)
    );

    always #5 clk = ~clk;

    // Strobes are sampled mid-cycle; the pop lands on the following edge.
    always @(negedge clk) begin
        pop_pend = rd_uart;
        if (wr_uart) begin
            txq.push_back(w_data);
            last_wr_valid = pkt_valid;
            n_wr++;
        end
        if (err_chk) n_err_chk++;
        if (err_len) n_err_len++;
        if (err_timeout) n_err_tmo++;
    end

    // First-word fall-through RX FIFO presented to the DUT.
    always @(posedge clk) begin
        #1;
        if (pop_pend && rxq.size() > 0) void'(rxq.pop_front());
        rx_empty = (rxq.size() == 0);
        r_data   = rx_empty ? 8'h00 : rxq[0];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame-level parse of frm from HUNT: 0 good, 1 bad checksum, 2 bad length, 3 incomplete.
    task automatic predict();
        int i;
        int x;
        exp_kind = 3;
        exp_len  = 0;
        i = 0;
        while (i < frm.size() && frm[i] != SOF) i++;
        i++;
        if (i >= frm.size()) return;
        exp_len = int'(frm[i]);
        i++;
        if (exp_len == 0 || exp_len > MAX_LEN) begin
            exp_kind = 2;
            return;
        end
        x = exp_len;
        for (int k = 0; k < exp_len; k++) begin
            if (i >= frm.size()) return;
            exp_pl[k] = frm[i];
            x = x ^ int'(frm[i]);
            i++;
        end
        if (i >= frm.size()) return;
        exp_kind = (int'(frm[i]) == x) ? 0 : 1;
    endtask

    task automatic push_frame();
        predict();
        snap_wr  = n_wr;
        snap_chk = n_err_chk;
        snap_len = n_err_len;
        snap_tmo = n_err_tmo;
        foreach (frm[k]) rxq.push_back(frm[k]);
    endtask

    task automatic wait_tx(input string tag, input logic [7:0] exp_byte);
        int t = 0;
        do begin
            @(posedge clk);
            t++;
        end while (txq.size() == 0 && t < 500);
        #1;
        if (txq.size() == 0) check({tag, "_no_tx"}, 0, 1);
        else check({tag, "_tx"}, txq.pop_front(), exp_byte);
    endtask

    task automatic ack_pkt();
        @(posedge clk);
        #1 pkt_ack = 1'b1;
        @(posedge clk);
        #1 pkt_ack = 1'b0;
        check("valid_after_ack", pkt_valid, 0);
    endtask

    task automatic expect_result(input bit do_ack);
        int errs;
        case (exp_kind)
            0: begin
                wait_tx("ack", ACK);
                exp_count = exp_count + 16'd1;
                check("valid_with_ack", last_wr_valid, 1);
                check("pkt_valid", pkt_valid, 1);
                check("pkt_len", pkt_len, exp_len);
                check("pkt_count", pkt_count, exp_count);
                for (int k = 0; k < exp_len; k++) begin
                    pkt_rd_addr = k[3:0];
                    #1;
                    check("payload", pkt_rd_data, exp_pl[k]);
                end
                if (do_ack) ack_pkt();
            end
            1: begin
                wait_tx("nak_chk", NAK);
                check("err_chk_pulse", n_err_chk - snap_chk, 1);
                check("valid_after_nak", pkt_valid, 0);
                check("count_after_nak", pkt_count, exp_count);
            end
            2: begin
                wait_tx("nak_len", NAK);
                check("err_len_pulse", n_err_len - snap_len, 1);
                check("valid_after_len", pkt_valid, 0);
            end
            default: ;
        endcase
        errs = (n_err_chk - snap_chk) + (n_err_len - snap_len) + (n_err_tmo - snap_tmo);
        check("err_total", errs, (exp_kind == 0) ? 0 : 1);
        check("one_push", n_wr - snap_wr, 1);
    endtask

    task automatic build_random();
        int kind, len, g;
        logic [7:0] x, b;
        frm.delete();
        g = $urandom_range(0, 3);
        repeat (g) begin
            b = 8'($urandom_range(0, 255));
            if (b == SOF) b = 8'h00;
            frm.push_back(b);
        end
        kind = $urandom_range(0, 9);
        frm.push_back(SOF);
        if (kind < 2) begin
            b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255));
            frm.push_back(b);
        end else begin
            len = $urandom_range(1, MAX_LEN);
            frm.push_back(8'(len));
            x = 8'(len);
            repeat (len) begin
                b = 8'($urandom_range(0, 255));
                frm.push_back(b);
                x = x ^ b;
            end
            if (kind < 4) x = x ^ 8'($urandom_range(1, 255));
            frm.push_back(x);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t;
        reset       = 1'b1;
        tx_full     = 1'b0;
        pkt_ack     = 1'b0;
        pkt_rd_addr = '0;
        exp_count   = '0;
        tick(3);
        check("rst_rd_uart", rd_uart, 0);
        check("rst_wr_uart", wr_uart, 0);
        check("rst_pkt_valid", pkt_valid, 0);
        check("rst_pkt_len", pkt_len, 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_errs", {err_chk, err_len, err_timeout}, 0);
        reset = 1'b0;
        tick(2);

        frm = {8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        push_frame();
        expect_result(1'b1);

        frm = {8'h7E, 8'h02, 8'hAA, 8'h55, 8'h00};
        push_frame();
        expect_result(1'b1);

        frm = {8'h7E, 8'h00};
        push_frame();
        expect_result(1'b1);
        frm = {8'h7E, 8'h11};
        push_frame();
        expect_result(1'b1);
        frm = {8'h7E, 8'h02, 8'h01, 8'h02, 8'h01};
        push_frame();
        expect_result(1'b1);

        // Second frame must stay queued in the RX FIFO while the first is held.
        frm = {8'h00, 8'hFF, 8'h7E, 8'h01, 8'h5A, 8'h5B};
        push_frame();
        expect_result(1'b0);
        frm = {8'h7E, 8'h02, 8'h33, 8'h44, 8'h75};
        push_frame();
        tick(20);
        check("hold_no_pop", rd_uart, 0);
        check("hold_rx_full", rx_empty, 0);
        check("hold_rxq", rxq.size(), 5);
        ack_pkt();
        expect_result(1'b1);

        frm = {8'h7E, 8'h04, 8'h01};
        push_frame();
        t = 0;
        while (n_err_tmo == snap_tmo && t < TIMEOUT + 50) begin
            tick(1);
            t++;
        end
        tick(1);
        check("tmo_pulse", n_err_tmo - snap_tmo, 1);
        check("tmo_window", (t >= TIMEOUT && t <= TIMEOUT + 8), 1);
        check("tmo_no_tx", n_wr - snap_wr, 0);
        check("tmo_no_other_err", (n_err_chk - snap_chk) + (n_err_len - snap_len), 0);
        frm = {8'h7E, 8'h01, 8'h09, 8'h08};
        push_frame();
        expect_result(1'b1);

        tx_full = 1'b1;
        frm = {8'h7E, 8'h02, 8'hA0, 8'h0B, 8'hA9};
        push_frame();
        tick(50);
        check("bp_no_wr", n_wr - snap_wr, 0);
        check("bp_valid", pkt_valid, 0);
        tx_full = 1'b0;
        expect_result(1'b1);

        frm = {8'h7E, 8'h02, 8'h10};
        push_frame();
        tick(6);
        reset = 1'b1;
        rxq.push_back(8'h55);
        tick(2);
        check("mid_rst_rx_full", rx_empty, 0);
        check("mid_rst_rd_uart", rd_uart, 0);
        check("mid_rst_wr_uart", wr_uart, 0);
        check("mid_rst_count", pkt_count, 0);
        check("mid_rst_valid", pkt_valid, 0);
        exp_count = '0;
        rxq.delete();
        tick(1);
        reset = 1'b0;
        tick(2);
        check("rst_drop_no_tx", n_wr - snap_wr, 0);
        check("rst_drop_no_err",
              (n_err_chk - snap_chk) + (n_err_len - snap_len) + (n_err_tmo - snap_tmo), 0);
        frm = {8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        push_frame();
        expect_result(1'b1);

        for (int f = 0; f < 30; f++) begin
            build_random();
            push_frame();
            if ($urandom_range(0, 3) == 0) begin
                tx_full = 1'b1;
                tick($urandom_range(5, 20));
                tx_full = 1'b0;
            end
            expect_result(1'b1);
        end

        tick(5);
        check("txq_drained", txq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
